// File: rtl/eviction_tracker_drain.sv
// eviction_tracker_drain: streams tracker buffer entries out as packed words, then pulses a stall clear.
module eviction_tracker_drain #(
  parameter int COUNTER_BW   = 30,
  parameter int BUFFER_LIMIT = 1024,
  parameter int RD_LATENCY   = 2,
  parameter int BW_BUFFER    = $clog2(BUFFER_LIMIT)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [31:0]           count_i,
  input  logic [COUNTER_BW-1:0] trace_i,
  input  logic [1:0]            status_i,
  output logic [BW_BUFFER-1:0]  addr_o,
  output logic [31:0]           data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  clear_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic [31:0]           words_o
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, PUSH = 2'd2, CLEAR = 2'd3;
  localparam int NW = BW_BUFFER + 1;
  localparam int WW = RD_LATENCY > 1 ? $clog2(RD_LATENCY) : 1;
  if (COUNTER_BW > 30 || RD_LATENCY < 1) begin : g_bad_params
    $error("eviction_tracker_drain: COUNTER_BW must be <= 30 and RD_LATENCY >= 1");
  end
  logic [1:0] state;
  logic [NW-1:0] n, n_in;
  logic [BW_BUFFER-1:0] idx;
  logic [WW-1:0] wcnt;
  logic [31:0] word;
  logic last;
  assign n_in = count_i >= 32'(BUFFER_LIMIT) ? NW'(BUFFER_LIMIT) : count_i[NW-1:0];
  assign word = {status_i, 30'b0} | 32'(trace_i);
  assign last = {1'b0, idx} == n - NW'(1);
  assign clear_o = state == CLEAR;
  assign done_o = state == CLEAR;
  assign busy_o = state != IDLE;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
      n <= '0;
      idx <= '0;
      wcnt <= '0;
      addr_o <= '0;
      data_o <= '0;
      valid_o <= 1'b0;
      words_o <= '0;
    end else begin
      case (state)
        IDLE: if (enable_i & (stall_i | flush_i)) begin
          n <= n_in;
          idx <= '0;
          addr_o <= '0;
          wcnt <= '0;
          state <= n_in == '0 ? CLEAR : READ;
        end
        READ: if (wcnt == WW'(RD_LATENCY - 1)) begin
          data_o <= word;
          valid_o <= 1'b1;
          state <= PUSH;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
        PUSH: if (ready_i) begin
          valid_o <= 1'b0;
          words_o <= words_o + 32'd1;
          if (last) begin
            state <= CLEAR;
          end else begin
            idx <= idx + 1'b1;
            addr_o <= idx + 1'b1;
            wcnt <= '0;
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
